header_loader: RTL and testbench

HEADER_LOADER -- requirements
Module: header_loader

---
 rtl/header_loader.sv | 107 ++++++++++
 tb/tb_header_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_loader.sv
// Byte-serial block-header loader: assembles an 80-byte frame in a shadow register,
// then commits it to the miner's header input behind a fixed-length miner reset pulse.
module header_loader #(
    parameter int RST_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [639:0] header,
    output logic         miner_rst,
    output logic         header_valid,
    output logic         frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT,
        HOLD
    } state_t;

    localparam logic [6:0] LAST_IDX  = 7'd79;
    localparam logic [3:0] HOLD_LOAD = 4'(RST_CYCLES - 1);

    state_t       state;
    logic [6:0]   count;
    logic [3:0]   hold_cnt;
    logic [639:0] shadow;
    logic         take;

    // NOTE: in_ready is gated by rst combinationally so no byte can be taken on a reset cycle.
    assign in_ready = !rst && (state == IDLE || state == RECV);
    assign take     = in_valid && in_ready;

    // NOTE: shadow has no reset; count restarts at 0 and every byte is rewritten before a commit.
    always_ff @(posedge clk) begin
        if (take) begin
            shadow[10'd639 - {count, 3'b000} -: 8] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            hold_cnt     <= '0;
            header       <= '0;
            header_valid <= 1'b0;
            frame_err    <= 1'b0;
            miner_rst    <= 1'b1;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    miner_rst <= 1'b0;
                    if (take) begin
                        if (in_last) begin
                            frame_err <= 1'b1;
                            count     <= '0;
                        end else begin
                            count <= 7'd1;
                            state <= RECV;
                        end
                    end
                end

                RECV: begin
                    miner_rst <= 1'b0;
                    if (take) begin
                        if (in_last != (count == LAST_IDX)) begin
                            frame_err <= 1'b1;
                            count     <= '0;
                            state     <= IDLE;
                        end else if (in_last) begin
                            // The final byte bypasses shadow so header updates in one step.
                            header       <= {shadow[639:8], in_data};
                            header_valid <= 1'b1;
                            miner_rst    <= 1'b1;
                            hold_cnt     <= HOLD_LOAD;
                            count        <= '0;
                            state        <= COMMIT;
                        end else begin
                            count <= count + 7'd1;
                        end
                    end
                end

                // COMMIT is the first cycle of the miner reset window; HOLD covers the rest.
                COMMIT, HOLD: begin
                    if (hold_cnt != 4'd0) begin
                        hold_cnt <= hold_cnt - 4'd1;
                        state    <= HOLD;
                    end else begin
                        miner_rst <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_header_loader.sv
// Self-checking bench for header_loader: a reset/error vector table, directed frame
// sequences and randomized frames, all compared against a frame-level reference model.
module tb_header_loader;

    localparam int RC_A = 2;
    localparam int RC_B = 1;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       exp_ready;
        logic       exp_mrst;
        logic       exp_hv;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst   [2];
    logic       t_valid [2];
    logic [7:0] t_data  [2];
    logic       t_last  [2];

    logic         a_ready, a_mrst, a_hv, a_err;
    logic         b_ready, b_mrst, b_hv, b_err;
    logic [639:0] a_hdr, b_hdr;

    header_loader #(.RST_CYCLES(RC_A)) dut_a (
        .clk(clk), .rst(t_rst[0]), .in_data(t_data[0]), .in_valid(t_valid[0]),
        .in_last(t_last[0]), .in_ready(a_ready), .header(a_hdr), .miner_rst(a_mrst),
        .header_valid(a_hv), .frame_err(a_err)
    );

    header_loader #(.RST_CYCLES(RC_B)) dut_b (
        .clk(clk), .rst(t_rst[1]), .in_data(t_data[1]), .in_valid(t_valid[1]),
        .in_last(t_last[1]), .in_ready(b_ready), .header(b_hdr), .miner_rst(b_mrst),
        .header_valid(b_hv), .frame_err(b_err)
    );

    // Reference model: a frame accumulator plus a count of remaining miner-reset cycles.
    logic [639:0] m_acc  [2];
    logic [639:0] m_hdr  [2];
    int           m_n    [2];
    int           m_busy [2];
    logic         m_hv   [2];
    logic         m_err  [2];
    logic         m_mrst [2];

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    logic         took [2];
    logic         pre_ready [2];
    int           last_take_cyc [2];
    int           first_take_cyc [2];
    int           mrst_hi [2];
    int           mrst_rise [2];
    int           err_cnt [2];
    int           notready [2];
    int           hdr_changes [2];
    logic         prev_mrst [2];
    logic [639:0] prev_hdr [2];
    logic [7:0]   fr [80];
    logic [639:0] golden;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input int id, input logic r, input logic v,
                              input logic [7:0] d, input logic l);
        if (r) begin
            m_n[id]    = 0;
            m_hdr[id]  = '0;
            m_hv[id]   = 1'b0;
            m_err[id]  = 1'b0;
            m_mrst[id] = 1'b1;
            m_busy[id] = 0;
        end else begin
            m_err[id] = 1'b0;
            if (m_busy[id] > 0) begin
                m_busy[id]--;
                m_mrst[id] = (m_busy[id] > 0);
            end else begin
                m_mrst[id] = 1'b0;
                if (v) begin
                    m_acc[id] = {m_acc[id][631:0], d};
                    m_n[id]++;
                    if (l != (m_n[id] == 80)) begin
                        m_err[id] = 1'b1;
                        m_n[id]   = 0;
                    end else if (l) begin
                        m_hdr[id]  = m_acc[id];
                        m_hv[id]   = 1'b1;
                        m_mrst[id] = 1'b1;
                        m_busy[id] = (id == 0) ? RC_A : RC_B;
                        m_n[id]    = 0;
                    end
                end
            end
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        logic         exp_r [2];
        logic         oready [2];
        logic         om [2];
        logic         ov [2];
        logic         oe [2];
        logic [639:0] oh [2];
        string        pfx;
        #1;
        oready[0] = a_ready;
        oready[1] = b_ready;
        for (int i = 0; i < 2; i++) begin
            exp_r[i]     = !t_rst[i] && (m_busy[i] == 0);
            pre_ready[i] = oready[i];
            took[i]      = exp_r[i] && t_valid[i];
            if (!t_rst[i] && !oready[i]) notready[i]++;
        end
        check("a_in_ready", oready[0], exp_r[0]);
        check("b_in_ready", oready[1], exp_r[1]);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, t_rst[i], t_valid[i], t_data[i], t_last[i]);
        cyc++;
        #1;
        oh[0] = a_hdr;  om[0] = a_mrst;  ov[0] = a_hv;  oe[0] = a_err;
        oh[1] = b_hdr;  om[1] = b_mrst;  ov[1] = b_hv;  oe[1] = b_err;
        for (int i = 0; i < 2; i++) begin
            pfx = (i == 0) ? "a" : "b";
            if (took[i]) last_take_cyc[i] = cyc;
            check({pfx, "_header"}, oh[i], m_hdr[i]);
            check({pfx, "_header_valid"}, ov[i], m_hv[i]);
            check({pfx, "_miner_rst"}, om[i], m_mrst[i]);
            check({pfx, "_frame_err"}, oe[i], m_err[i]);
            if (!t_rst[i] && om[i]) mrst_hi[i]++;
            if (!t_rst[i] && om[i] && !prev_mrst[i]) mrst_rise[i]++;
            if (oe[i]) err_cnt[i]++;
            if (oh[i] !== prev_hdr[i]) hdr_changes[i]++;
            prev_mrst[i] = om[i];
            prev_hdr[i]  = oh[i];
        end
        @(negedge clk);
    endtask

    task automatic clear_counters();
        for (int i = 0; i < 2; i++) begin
            mrst_hi[i] = 0; mrst_rise[i] = 0; err_cnt[i] = 0; notready[i] = 0; hdr_changes[i] = 0;
        end
    endtask

    // Stall cycles carry random data and in_last, which must be ignored.
    task automatic idle(input int n);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 2; i++) begin
                t_valid[i] = 1'b0;
                t_data[i]  = 8'($urandom);
                t_last[i]  = 1'($urandom);
            end
            tick();
        end
    endtask

    task automatic send_byte(input int id, input logic [7:0] d, input logic l, input int smax);
        int stalls;
        bit ok;
        stalls = (smax > 0) ? int'($urandom_range(smax, 0)) : 0;
        for (int s = 0; s < stalls; s++) begin
            t_valid[id] = 1'b0;
            t_data[id]  = 8'($urandom);
            t_last[id]  = 1'($urandom);
            tick();
        end
        t_valid[id] = 1'b1;
        t_data[id]  = d;
        t_last[id]  = l;
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            tick();
            ok = took[id];
        end
        if (!ok) check("accept_timeout", ok, 1'b1);
    endtask

    task automatic send_frame(input int id, input int last_at, input int smax, input int abort_at);
        for (int k = 0; k < 80; k++) begin
            if (k == abort_at) break;
            send_byte(id, fr[k], k == last_at, smax);
            if (k == 0) first_take_cyc[id] = last_take_cyc[id];
            if (k == last_at) break;
        end
    endtask

    task automatic reset_pulse(input int id, input int n);
        t_valid[id] = 1'b0;
        t_rst[id]   = 1'b1;
        for (int s = 0; s < n; s++) tick();
        t_rst[id] = 1'b0;
    endtask

    task automatic fill_test_frame();
        for (int k = 0; k < 80; k++) fr[k] = 8'(k * 29 + 7);
        fr[0] = 8'h01; fr[1] = 8'h00; fr[2] = 8'h00; fr[3] = 8'h00; fr[4] = 8'h50; fr[5] = 8'h12;
        fr[72] = 8'h4c; fr[73] = 8'h86; fr[74] = 8'h04; fr[75] = 8'h1b;
        for (int k = 76; k < 80; k++) fr[k] = 8'h00;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 80; k++) fr[k] = 8'($urandom);
    endtask

    initial begin
        vec_t tbl [9];
        int   kind;

        for (int i = 0; i < 2; i++) begin
            t_rst[i] = 1'b1; t_valid[i] = 1'b0; t_data[i] = 8'h00; t_last[i] = 1'b0;
            m_n[i] = 0; m_busy[i] = 0; m_hdr[i] = '0; m_hv[i] = 1'b0; m_err[i] = 1'b0;
            m_mrst[i] = 1'b1; prev_mrst[i] = 1'b0; prev_hdr[i] = '0;
            last_take_cyc[i] = 0; first_take_cyc[i] = 0;
        end
        clear_counters();

        //         rst   valid  data   last  ready mrst  hv    err
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'haa, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            t_rst[0] = tbl[i].rst; t_valid[0] = tbl[i].valid;
            t_data[0] = tbl[i].data; t_last[0] = tbl[i].last;
            tick();
            check("tbl_in_ready", pre_ready[0], tbl[i].exp_ready);
            check("tbl_miner_rst", a_mrst, tbl[i].exp_mrst);
            check("tbl_header_valid", a_hv, tbl[i].exp_hv);
            check("tbl_frame_err", a_err, tbl[i].exp_err);
        end
        t_rst[1] = 1'b0;
        idle(2);

        // Single back-to-back load of the test header.
        fill_test_frame();
        clear_counters();
        send_frame(0, 79, 0, 80);
        idle(4);
        check("load_header_top", a_hdr[639:592], 48'h010000005012);
        check("load_header_tail", a_hdr[63:0], 64'h4c86041b00000000);
        check("load_header_valid", a_hv, 1'b1);
        check("load_miner_rst_cycles", mrst_hi[0], RC_A);
        check("load_ready_low_cycles", notready[0], RC_A);
        golden = m_hdr[0];

        // Same frame with random stalls between bytes.
        clear_counters();
        send_frame(0, 79, 3, 80);
        idle(4);
        check("stall_header", a_hdr, golden);
        check("stall_commit_count", mrst_rise[0], 1);

        // in_last on byte 40.
        clear_counters();
        fill_random();
        send_frame(0, 40, 2, 80);
        idle(2);
        check("early_err_pulses", err_cnt[0], 1);
        check("early_header_kept", a_hdr, golden);
        check("early_valid_kept", a_hv, 1'b1);
        check("early_no_commit", mrst_rise[0], 0);
        fill_random();
        send_frame(0, 79, 1, 80);
        idle(4);
        check("after_early_commit_count", mrst_rise[0], 1);

        // No in_last on byte 79.
        clear_counters();
        fill_random();
        send_frame(0, -1, 1, 80);
        idle(3);
        check("missing_err_pulses", err_cnt[0], 1);
        check("missing_no_miner_rst", mrst_hi[0], 0);
        check("missing_back_in_idle", pre_ready[0], 1'b1);

        // Reset after byte 30.
        clear_counters();
        fill_random();
        send_frame(0, 79, 1, 31);
        reset_pulse(0, 3);
        check("midrst_header", a_hdr, 640'h0);
        check("midrst_header_valid", a_hv, 1'b0);
        check("midrst_miner_rst", a_mrst, 1'b1);
        check("midrst_ready", pre_ready[0], 1'b0);
        idle(1);
        check("midrst_release_miner_rst", a_mrst, 1'b0);
        fill_random();
        send_frame(0, 79, 1, 80);
        idle(4);
        check("midrst_reload_valid", a_hv, 1'b1);
        check("midrst_reload_commits", mrst_rise[0], 1);

        // Reset landing inside the hold window.
        fill_random();
        send_frame(0, 79, 0, 80);
        reset_pulse(0, 1);
        idle(3);
        check("holdrst_header", a_hdr, 640'h0);

        // Randomized frames: good, early last, missing last, reset mid-frame or mid-hold.
        for (int f = 0; f < 24; f++) begin
            kind = int'($urandom_range(4, 0));
            fill_random();
            case (kind)
                0: send_frame(0, 79, 3, 80);
                1: send_frame(0, int'($urandom_range(78, 0)), 2, 80);
                2: send_frame(0, -1, 1, 80);
                3: begin
                    send_frame(0, 79, 1, int'($urandom_range(79, 1)));
                    reset_pulse(0, int'($urandom_range(3, 1)));
                end
                default: begin
                    send_frame(0, 79, 0, 80);
                    reset_pulse(0, 1);
                end
            endcase
            idle(3);
        end

        // RST_CYCLES=1 instance: frame A then frame B with in_valid held high throughout.
        clear_counters();
        fill_random();
        send_frame(1, 79, 0, 80);
        golden = m_hdr[1];
        check("b2b_first_header", b_hdr, golden);
        kind = last_take_cyc[1];
        fill_random();
        send_frame(1, 79, 0, 80);
        idle(3);
        check("b2b_first_byte_gap", first_take_cyc[1] - kind, 2);
        check("b2b_header_changes", hdr_changes[1], 2);
        check("b2b_miner_rst_cycles", mrst_hi[1], 2);
        check("b2b_miner_rst_pulses", mrst_rise[1], 2);
        check("b2b_header_valid", b_hv, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
